// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file write path.
// The mult/div return FIFO and the write arbiter both use these definitions.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] regIdx;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/md_return_fifo.sv
// Small synchronous FIFO for mult/div results waiting for the register-file write port.
// It exports per-slot valid bits and destination indices so the owner can run hazard lookups.
module md_return_fifo
  import regfile_pkg::*;
#(
  parameter int Q_DEPTH = 4
) (
  input  logic                            CLOCK,
  input  logic                            RESET,
  input  logic                            Push,
  input  wr_req_t                         PushEntry,
  input  logic                            Pop,
  output wr_req_t                         Head,
  output logic                            Full,
  output logic                            Empty,
  output logic [Q_DEPTH-1:0]              EntryValid,
  output logic [Q_DEPTH-1:0][ADDR_W-1:0]  EntryRegs
);

  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  wr_req_t          mem [Q_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign Full   = (count == CNT_W'(Q_DEPTH));
  assign Empty  = (count == '0);
  assign doPush = Push & ~Full;
  assign doPop  = Pop & ~Empty;
  assign Head   = mem[rdPtr];

  // Entry storage carries data only, so it is not reset; occupancy is tracked by count.
  always_ff @(posedge CLOCK) begin
    if (doPush) mem[wrPtr] <= PushEntry;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] offs;
    offs       = '0;
    EntryValid = '0;
    EntryRegs  = '0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      offs          = PTR_W'(i) - rdPtr;
      EntryValid[i] = ({1'b0, offs} < count);
      EntryRegs[i]  = mem[i].regIdx;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between writeback and the queued mult/div results,
// with a starvation-driven one-cycle stall and a pending-write lookup for the hazard unit.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int Q_DEPTH      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              WB_Valid_IN,
  input  logic [ADDR_W-1:0] WB_Register_IN,
  input  logic [DATA_W-1:0] WB_Data_IN,
  input  logic              MD_Valid_IN,
  output logic              MD_Ready_OUT,
  input  logic [ADDR_W-1:0] MD_Register_IN,
  input  logic [DATA_W-1:0] MD_Data_IN,
  input  logic [ADDR_W-1:0] Query_Register_IN,
  output logic              QueryHit_OUT,
  output logic              Stall_OUT,
  output logic              WriteEnable_OUT,
  output logic [ADDR_W-1:0] WriteRegister_OUT,
  output logic [DATA_W-1:0] WriteData_OUT
);

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wr_req_t                        fifoHead;
  wr_req_t                        mdEntry;
  wr_req_t                        grantReq;
  logic                           fifoFull;
  logic                           fifoEmpty;
  logic [Q_DEPTH-1:0]             entryValid;
  logic [Q_DEPTH-1:0][ADDR_W-1:0] entryRegs;
  logic                           outOfReset_p0;
  logic                           grantFifo;
  logic                           grantWb;
  logic                           stallNext;
  logic [STV_W-1:0]               starveCnt_p0;
  logic [STV_W-1:0]               starveNext;

  // Ready is held low while in reset and for the edge that releases it.
  assign MD_Ready_OUT   = outOfReset_p0 & ~fifoFull;
  assign mdEntry.regIdx = MD_Register_IN;
  assign mdEntry.data   = MD_Data_IN;

  md_return_fifo #(.Q_DEPTH(Q_DEPTH)) uFifo (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .Push       (MD_Valid_IN & MD_Ready_OUT),
    .PushEntry  (mdEntry),
    .Pop        (grantFifo),
    .Head       (fifoHead),
    .Full       (fifoFull),
    .Empty      (fifoEmpty),
    .EntryValid (entryValid),
    .EntryRegs  (entryRegs)
  );

  // During a stall the pipeline holds its writeback, so the queue head owns the port.
  always_comb begin
    grantWb   = ~Stall_OUT & WB_Valid_IN;
    grantFifo = ~fifoEmpty & ~grantWb;
    grantReq  = fifoHead;
    if (!grantFifo) begin
      grantReq.regIdx = WB_Register_IN;
      grantReq.data   = WB_Data_IN;
    end
  end

  always_comb begin
    starveNext = '0;
    stallNext  = 1'b0;
    if (!fifoEmpty && !grantFifo) begin
      if (starveCnt_p0 == STV_W'(STARVE_LIMIT - 1)) stallNext = 1'b1;
      else starveNext = starveCnt_p0 + STV_W'(1);
    end
  end

  always_comb begin
    QueryHit_OUT = 1'b0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      if (entryValid[i] && (entryRegs[i] == Query_Register_IN)) QueryHit_OUT = 1'b1;
    end
    if (Query_Register_IN == REG_ZERO) QueryHit_OUT = 1'b0;
  end

  // p0 -> p1: grant result registered onto the register-file write port.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      outOfReset_p0     <= 1'b0;
      starveCnt_p0      <= '0;
      Stall_OUT         <= 1'b0;
      WriteEnable_OUT   <= 1'b0;
      WriteRegister_OUT <= '0;
      WriteData_OUT     <= '0;
    end else begin
      outOfReset_p0 <= 1'b1;
      starveCnt_p0  <= starveNext;
      Stall_OUT     <= stallNext;
      if (grantFifo || grantWb) begin
        WriteEnable_OUT   <= (grantReq.regIdx != REG_ZERO);
        WriteRegister_OUT <= grantReq.regIdx;
        WriteData_OUT     <= grantReq.data;
      end else begin
        WriteEnable_OUT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random checks of the write arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int Q_DEPTH      = 4;
  localparam int STARVE_LIMIT = 3;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic              WB_Valid_IN;
  logic [ADDR_W-1:0] WB_Register_IN;
  logic [DATA_W-1:0] WB_Data_IN;
  logic              MD_Valid_IN;
  logic              MD_Ready_OUT;
  logic [ADDR_W-1:0] MD_Register_IN;
  logic [DATA_W-1:0] MD_Data_IN;
  logic [ADDR_W-1:0] Query_Register_IN;
  logic              QueryHit_OUT;
  logic              Stall_OUT;
  logic              WriteEnable_OUT;
  logic [ADDR_W-1:0] WriteRegister_OUT;
  logic [DATA_W-1:0] WriteData_OUT;

  always #5 CLOCK = ~CLOCK;

  regfile_write_arbiter #(.Q_DEPTH(Q_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLOCK             (CLOCK),
    .RESET             (RESET),
    .WB_Valid_IN       (WB_Valid_IN),
    .WB_Register_IN    (WB_Register_IN),
    .WB_Data_IN        (WB_Data_IN),
    .MD_Valid_IN       (MD_Valid_IN),
    .MD_Ready_OUT      (MD_Ready_OUT),
    .MD_Register_IN    (MD_Register_IN),
    .MD_Data_IN        (MD_Data_IN),
    .Query_Register_IN (Query_Register_IN),
    .QueryHit_OUT      (QueryHit_OUT),
    .Stall_OUT         (Stall_OUT),
    .WriteEnable_OUT   (WriteEnable_OUT),
    .WriteRegister_OUT (WriteRegister_OUT),
    .WriteData_OUT     (WriteData_OUT)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of pending results plus a count of cycles spent waiting.
  wr_req_t           mq[$];
  int                waitCycles;
  bit                stallM;
  bit                readyUp;
  bit                expWe;
  logic [ADDR_W-1:0] expReg;
  logic [DATA_W-1:0] expData;
  bit                lastGrantWb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    waitCycles = 0;
    stallM     = 1'b0;
    readyUp    = 1'b0;
    expWe      = 1'b0;
    expReg     = '0;
    expData    = '0;
  endtask

  function automatic bit modelHit(input logic [ADDR_W-1:0] q);
    if (q == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].regIdx == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    WB_Valid_IN = 1'b0;
    MD_Valid_IN = 1'b0;
  endtask

  task automatic setWb(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    WB_Valid_IN    = v;
    WB_Register_IN = r;
    WB_Data_IN     = d;
  endtask

  task automatic setMd(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    MD_Valid_IN    = v;
    MD_Register_IN = r;
    MD_Data_IN     = d;
  endtask

  // One clock: advance the model on the current inputs, clock the DUT, compare just after the edge.
  task automatic cycle();
    bit      gFifo;
    bit      gWb;
    bit      newStall;
    bit      rdy;
    wr_req_t h;
    wr_req_t e;
    rdy      = readyUp && (mq.size() < Q_DEPTH);
    gWb      = !stallM && WB_Valid_IN;
    gFifo    = (mq.size() > 0) && !gWb;
    newStall = 1'b0;
    if (mq.size() == 0 || gFifo) waitCycles = 0;
    else begin
      waitCycles++;
      if (waitCycles == STARVE_LIMIT) begin
        newStall   = 1'b1;
        waitCycles = 0;
      end
    end
    if (gFifo) begin
      h       = mq.pop_front();
      expWe   = (h.regIdx != 0);
      expReg  = h.regIdx;
      expData = h.data;
    end else if (gWb) begin
      expWe   = (WB_Register_IN != 0);
      expReg  = WB_Register_IN;
      expData = WB_Data_IN;
    end else begin
      expWe = 1'b0;
    end
    if (MD_Valid_IN && rdy) begin
      e.regIdx = MD_Register_IN;
      e.data   = MD_Data_IN;
      mq.push_back(e);
    end
    stallM      = newStall;
    readyUp     = 1'b1;
    lastGrantWb = gWb;
    @(posedge CLOCK);
    #1;
    check("we", WriteEnable_OUT, expWe);
    if (expWe) begin
      check("wreg", WriteRegister_OUT, expReg);
      check("wdata", WriteData_OUT, expData);
    end
    check("stall", Stall_OUT, stallM);
    check("ready", MD_Ready_OUT, mq.size() < Q_DEPTH);
    check("hit", QueryHit_OUT, modelHit(Query_Register_IN));
    check("stall_empty", Stall_OUT && (mq.size() == 0), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] wbSeqReg [6];
    logic [ADDR_W-1:0] expOrder [7];
    int                wbIdx;
    int                stalls;

    RESET = 1'b1;
    idle();
    setWb(1'b0, '0, '0);
    setMd(1'b0, '0, '0);
    Query_Register_IN = '0;
    modelReset();
    #12;
    check("rst_we", WriteEnable_OUT, 1'b0);
    check("rst_ready", MD_Ready_OUT, 1'b0);
    check("rst_stall", Stall_OUT, 1'b0);
    RESET = 1'b0;
    cycle();
    check("post_rst_ready", MD_Ready_OUT, 1'b1);

    // Reset mid-operation with three queued results.
    for (int i = 0; i < 3; i++) begin
      setWb(1'b1, 5'd20, 32'h2000 + i);
      setMd(1'b1, ADDR_W'(i + 1), 32'h300 + i);
      cycle();
    end
    idle();
    Query_Register_IN = 5'd2;
    #1;
    check("pre_rst_hit", QueryHit_OUT, 1'b1);
    #1 RESET = 1'b1;
    #1;
    check("arst_we", WriteEnable_OUT, 1'b0);
    check("arst_wreg", WriteRegister_OUT, '0);
    check("arst_wdata", WriteData_OUT, '0);
    check("arst_ready", MD_Ready_OUT, 1'b0);
    check("arst_hit", QueryHit_OUT, 1'b0);
    check("arst_stall", Stall_OUT, 1'b0);
    #1 RESET = 1'b0;
    modelReset();
    cycle();
    check("rel_ready", MD_Ready_OUT, 1'b1);
    check("rel_hit", QueryHit_OUT, 1'b0);

    // Single writeback.
    setWb(1'b1, 5'd5, 32'h11);
    cycle();
    check("wb_we", WriteEnable_OUT, 1'b1);
    check("wb_reg", WriteRegister_OUT, 5'd5);
    check("wb_data", WriteData_OUT, 32'h11);
    idle();
    cycle();
    check("wb_we_off", WriteEnable_OUT, 1'b0);

    // Fill the queue behind a busy writeback, then drain with a blocked enqueue on the full cycle.
    for (int i = 0; i < 4; i++) begin
      setWb(1'b1, 5'd20, 32'h4000 + i);
      setMd(1'b1, ADDR_W'(8 + i), 32'h800 + i);
      cycle();
    end
    check("full_ready", MD_Ready_OUT, 1'b0);
    setWb(1'b0, 5'd20, 32'h0);
    setMd(1'b1, 5'd12, 32'hC00);
    cycle();
    check("drain_r8", WriteRegister_OUT, 5'd8);
    check("deq_full_ready", MD_Ready_OUT, 1'b1);
    idle();
    for (int i = 1; i < 4; i++) begin
      cycle();
      check("drain_order", WriteRegister_OUT, ADDR_W'(8 + i));
    end
    cycle();
    check("drain_done_we", WriteEnable_OUT, 1'b0);

    // Writeback held every cycle while one result waits: starvation stall.
    wbSeqReg = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    expOrder = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5, 5'd6};
    wbIdx  = 0;
    stalls = 0;
    for (int c = 0; c < 7; c++) begin
      setWb(1'b1, wbSeqReg[wbIdx], 32'h100 + wbIdx);
      setMd(c == 0, 5'd9, 32'h99);
      cycle();
      check("starve_order", WriteRegister_OUT, expOrder[c]);
      if (Stall_OUT) stalls++;
      if (lastGrantWb) wbIdx++;
    end
    check("starve_stalls", stalls, 1);
    check("starve_wb_count", wbIdx, 6);
    idle();
    cycle();

    // Register 0 dequeues silently; lookup of r3 stays live until it drains.
    Query_Register_IN = 5'd3;
    setWb(1'b1, 5'd21, 32'h21);
    setMd(1'b1, 5'd0, 32'hFF);
    cycle();
    setMd(1'b1, 5'd3, 32'h33);
    cycle();
    check("q3_hit", QueryHit_OUT, 1'b1);
    Query_Register_IN = 5'd0;
    #1;
    check("q0_hit", QueryHit_OUT, 1'b0);
    Query_Register_IN = 5'd3;
    idle();
    cycle();
    check("r0_we", WriteEnable_OUT, 1'b0);
    check("r0_q3_hit", QueryHit_OUT, 1'b1);
    cycle();
    check("r3_reg", WriteRegister_OUT, 5'd3);
    check("r3_hit_clear", QueryHit_OUT, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      setWb($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)), $urandom);
      setMd($urandom_range(0, 2) != 0, ADDR_W'($urandom_range(0, 7)), $urandom);
      Query_Register_IN = ADDR_W'($urandom_range(0, 7));
      cycle();
    end
    idle();
    for (int c = 0; c < 8; c++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
